dense_layer_sequencer: RTL
==========================

# dense_layer_sequencer

Control FSM for one fully connected layer of the CNN inference pipeline. Per output neuron, it steps the shared MAC datapath through every input index and then the bias index, stalling on upstream data availability. It then presents the result through a valid/ready handshake and moves on to the next neuron. It sits between the weight/input memories and the layer's MAC unit, and owns the input-index and neuron-index counters.

## Interface
- `INPUT_SIZE`, 16: inputs per neuron; the bias occupies index `INPUT_SIZE`.
- `LAYER_HEIGHT`, 8: neurons in the layer.
- `ADDR_W`, `$clog2(INPUT_SIZE+1)`: width of the input/weight index.
- `NEURON_W`, `max(1, $clog2(LAYER_HEIGHT))`: width of the neuron index.

Ports:
- `clk_i` in 1: sole clock, rising edge.
- `reset_n_i` in 1: asynchronous active-low reset.
- `start_i` in 1: begins a layer pass; sampled only in IDLE.
- `data_valid_i` in 1: upstream input word at `input_addr_o` is valid this cycle.
- `out_ready_i` in 1: downstream accepts the neuron result.
- `input_addr_o` out `ADDR_W`: input/weight index into memory.
- `neuron_addr_o` out `NEURON_W`: current neuron (weight row).
- `mac_en_o` out 1: MAC consumes an operand pair this cycle.
- `mac_clear_o` out 1: with `mac_en_o`, MAC loads the product instead of accumulating.
- `bias_sel_o` out 1: operand is the bias term.
- `result_valid_o` out 1: MAC result for `neuron_addr_o` is valid.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when the last neuron result is accepted.

## Operation
States: IDLE, ACCUM, BIAS, OUTPUT.

- **IDLE**
  - All outputs are 0.
  - `start_i` leads to ACCUM with `input_addr_o` = 0 and `neuron_addr_o` = 0.
- **ACCUM**
  - `mac_en_o` = `data_valid_i` (combinational from registered state).
  - `mac_clear_o` = (`input_addr_o` == 0). It stays high while stalled at index 0; this is harmless because `mac_en_o` is low.
  - Each cycle with `mac_en_o` high increments `input_addr_o`.
  - On `mac_en_o` with `input_addr_o` == `INPUT_SIZE`-1, go to BIAS.
  - `data_valid_i` low holds all state and counters.
- **BIAS**
  - Exactly one cycle; it does not depend on `data_valid_i`.
  - `input_addr_o` = `INPUT_SIZE`, and `bias_sel_o`, `mac_en_o` = 1.
  - Next state is OUTPUT.
- **OUTPUT**
  - `result_valid_o` = 1, held with `neuron_addr_o` stable until `out_ready_i`.
  - On the handshake with `neuron_addr_o` == `LAYER_HEIGHT`-1:
    - go to IDLE;
    - `done_o` is high in the handshake cycle (combinational: OUTPUT & `out_ready_i` & last neuron);
    - counters clear to 0.
  - On the handshake otherwise: increment `neuron_addr_o`, clear `input_addr_o`, go to ACCUM.

Other rules:
- `start_i` outside IDLE is ignored.
- Counters never wrap. Reaching the terminal values forces the transitions above.
- Reset, including mid-pass, asynchronously forces IDLE and zeroes all counters. The partially accumulated neuron is discarded.

## Timing
- Start to first `mac_en_o`: 1 cycle (start sampled at edge N; ACCUM from N+1).
- Per-neuron minimum: `INPUT_SIZE` ACCUM cycles, 1 BIAS cycle and 1 OUTPUT cycle, giving `INPUT_SIZE`+2 cycles when `data_valid_i` and `out_ready_i` are held high.
- Full layer minimum: `LAYER_HEIGHT`*(`INPUT_SIZE`+2) cycles from the first ACCUM cycle to `done_o`.
- A new `start_i` is accepted at the earliest in the first IDLE cycle after `done_o`.
- The MAC result is assumed ready the cycle after BIAS. A MAC with pipeline depth D needs a drain stage; that stage is out of scope here and D = 1 is fixed.
- Reset values: state IDLE, all outputs 0.

## Structure
- Package `dense_seq_pkg`:
  - `state_t` enum `{eIDLE, eACCUM, eBIAS, eOUTPUT}`;
  - helper function for `max(1, $clog2(n))`.
- Sub-module `index_counter`: parameterized width, async active-low reset, synchronous clear, increment enable. It is instantiated twice, for the input index and the neuron index.
- The FSM and output decode stay in the top module.

## Test plan
- Reset, then `INPUT_SIZE`=4, `LAYER_HEIGHT`=2, with `start_i` pulsed and valid/ready always high:
  - addresses 0,1,2,3, then BIAS at addr 4;
  - `result_valid_o` with neuron 0, then the same sequence for neuron 1;
  - `done_o` on cycle 12 after the first ACCUM cycle.
- `data_valid_i` low for 3 cycles at `input_addr_o`=2: address holds at 2 with `mac_en_o`=0, then resumes; `mac_clear_o` is seen only at index 0.
- `out_ready_i` low for 5 cycles in OUTPUT: `result_valid_o` and `neuron_addr_o` stay stable, with no `mac_en_o` and no counter movement.
- `start_i` pulsed mid-ACCUM and during OUTPUT: no effect, and the pass completes with the normal cycle count.
- `reset_n_i` dropped mid-BIAS of neuron 1, asynchronously (not on a clock edge):
  - outputs go to 0 immediately;
  - after release the block is in IDLE;
  - a fresh `start_i` restarts at neuron 0, index 0.
- `LAYER_HEIGHT`=1, `INPUT_SIZE`=1: sequence ACCUM(0), BIAS(1), OUTPUT, then `done_o` on the first handshake.

Source files
------------

// File: rtl/dense_seq_pkg.sv
// dense_seq_pkg: this package holds the state encoding and the sizing helper
// that the dense-layer sequencer uses.
`default_nettype none

package dense_seq_pkg;

  typedef enum logic [1:0] {
    eIDLE   = 2'd0,
    eACCUM  = 2'd1,
    eBIAS   = 2'd2,
    eOUTPUT = 2'd3
  } state_t;

  // Returns max(1, $clog2(n)). A single-neuron layer still needs a one-bit index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/index_counter.sv
// index_counter: an up-counter with an asynchronous active-low reset,
// a synchronous clear and an increment enable. Clear takes priority.
`default_nettype none

module index_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: this module steps a shared MAC through every input and
// then the bias for each neuron. It presents each result through a valid/ready
// handshake.
`default_nettype none

module dense_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter int INPUT_SIZE   = 16,
  parameter int LAYER_HEIGHT = 8,
  parameter int ADDR_W       = $clog2(INPUT_SIZE + 1),
  parameter int NEURON_W     = clog2_min1(LAYER_HEIGHT)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic                data_valid_i,
  input  logic                out_ready_i,
  output logic [ADDR_W-1:0]   input_addr_o,
  output logic [NEURON_W-1:0] neuron_addr_o,
  output logic                mac_en_o,
  output logic                mac_clear_o,
  output logic                bias_sel_o,
  output logic                result_valid_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [ADDR_W-1:0]   LAST_INPUT  = ADDR_W'(INPUT_SIZE - 1);
  localparam logic [NEURON_W-1:0] LAST_NEURON = NEURON_W'(LAYER_HEIGHT - 1);

  state_t state_d;
  state_t state_q;

  logic                in_idle;
  logic                in_accum;
  logic                in_bias;
  logic                in_output;
  logic                handshake;
  logic                last_input;
  logic                last_neuron;
  logic [ADDR_W-1:0]   input_idx;
  logic [NEURON_W-1:0] neuron_idx;

  assign in_idle     = (state_q == eIDLE);
  assign in_accum    = (state_q == eACCUM);
  assign in_bias     = (state_q == eBIAS);
  assign in_output   = (state_q == eOUTPUT);
  assign handshake   = in_output & out_ready_i;
  assign last_input  = (input_idx == LAST_INPUT);
  assign last_neuron = (neuron_idx == LAST_NEURON);

  always_comb begin
    state_d = state_q;
    case (state_q)
      eIDLE:   if (start_i) state_d = eACCUM;
      eACCUM:  if (data_valid_i && last_input) state_d = eBIAS;
      eBIAS:   state_d = eOUTPUT;
      eOUTPUT: if (out_ready_i) state_d = last_neuron ? eIDLE : eACCUM;
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The input index runs on past the last input and reaches INPUT_SIZE, which
  // is the bias slot.
  index_counter #(
    .WIDTH (ADDR_W)
  ) u_input_idx (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (in_idle | handshake),
    .inc_i     (in_accum & data_valid_i),
    .count_o   (input_idx)
  );

  index_counter #(
    .WIDTH (NEURON_W)
  ) u_neuron_idx (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (in_idle | (handshake & last_neuron)),
    .inc_i     (handshake & ~last_neuron),
    .count_o   (neuron_idx)
  );

  assign input_addr_o   = input_idx;
  assign neuron_addr_o  = neuron_idx;
  assign mac_en_o       = (in_accum & data_valid_i) | in_bias;
  assign mac_clear_o    = in_accum & (input_idx == '0);
  assign bias_sel_o     = in_bias;
  assign result_valid_o = in_output;
  assign busy_o         = ~in_idle;
  assign done_o         = handshake & last_neuron;

endmodule

`default_nettype wire
